// File: rtl/layernorm_engine_scheduler.sv
// Round-robin dispatcher for a pool of layernorm_1d engines using ap_start/ap_ready/ap_done,
// returning one (tag, engine) completion record per job through a registered valid/ready port.
module layernorm_engine_scheduler #(
    parameter int N_ENG = 4,
    parameter int TAG_W = 4,
    parameter int ENG_W = 2
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         job_valid,
    input  logic [TAG_W-1:0]             job_tag,
    output logic                         job_ready,
    output logic [N_ENG-1:0]             eng_start,
    input  logic [N_ENG-1:0]             eng_ready,
    input  logic [N_ENG-1:0]             eng_done,
    output logic                         cmp_valid,
    output logic [TAG_W-1:0]             cmp_tag,
    output logic [ENG_W-1:0]             cmp_eng,
    input  logic                         cmp_ready,
    output logic [$clog2(N_ENG+1)-1:0]   active_cnt,
    output logic                         err_spurious
);

    localparam int CNT_W = $clog2(N_ENG + 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_RUN, S_PEND} eng_state_t;

    eng_state_t         r_state [N_ENG];
    eng_state_t         w_state_nxt [N_ENG];
    logic [TAG_W-1:0]   r_tag [N_ENG];
    logic [N_ENG-1:0]   r_eng_start;
    logic [ENG_W-1:0]   r_rr_ptr;
    logic [ENG_W-1:0]   r_cmp_ptr;
    logic               r_cmp_valid;
    logic [TAG_W-1:0]   r_cmp_tag;
    logic [ENG_W-1:0]   r_cmp_eng;
    logic [CNT_W-1:0]   r_active_cnt;
    logic               r_err;

    logic [N_ENG-1:0]   w_idle_vec;
    logic [N_ENG-1:0]   w_pend_vec;
    logic               w_accept;
    logic               w_load;
    logic [ENG_W-1:0]   w_acc_sel;
    logic [ENG_W-1:0]   w_pend_sel;
    logic [N_ENG-1:0]   w_start_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               w_spur;

    // First requester at or after ptr, wrapping; two passes keep all indices constant.
    function automatic logic [ENG_W-1:0] rr_pick(input logic [N_ENG-1:0] req,
                                                 input logic [ENG_W-1:0] ptr);
        logic [ENG_W-1:0] sel;
        logic             found;
        sel   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < N_ENG; i++) begin
            if (!found && req[i] && (i >= 32'(ptr))) begin
                sel   = ENG_W'(i);
                found = 1'b1;
            end
        end
        for (int unsigned i = 0; i < N_ENG; i++) begin
            if (!found && req[i]) begin
                sel   = ENG_W'(i);
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    function automatic logic [ENG_W-1:0] ptr_inc(input logic [ENG_W-1:0] idx);
        return (idx == ENG_W'(N_ENG - 1)) ? '0 : idx + 1'b1;
    endfunction

    always_comb begin
        w_idle_vec = '0;
        w_pend_vec = '0;
        for (int unsigned i = 0; i < N_ENG; i++) begin
            w_idle_vec[i] = (r_state[i] == S_IDLE);
            w_pend_vec[i] = (r_state[i] == S_PEND);
        end
        w_accept   = job_valid && (|w_idle_vec);
        w_load     = (!r_cmp_valid || cmp_ready) && (|w_pend_vec);
        w_acc_sel  = rr_pick(w_idle_vec, r_rr_ptr);
        w_pend_sel = rr_pick(w_pend_vec, r_cmp_ptr);
    end

    always_comb begin
        w_spur      = 1'b0;
        w_start_nxt = '0;
        w_cnt_nxt   = '0;
        for (int unsigned i = 0; i < N_ENG; i++) begin
            w_state_nxt[i] = r_state[i];
            case (r_state[i])
                S_IDLE:  if (w_accept && (w_acc_sel == ENG_W'(i))) w_state_nxt[i] = S_START;
                S_START: if (eng_ready[i]) w_state_nxt[i] = eng_done[i] ? S_PEND : S_RUN;
                S_RUN:   if (eng_done[i]) w_state_nxt[i] = S_PEND;
                S_PEND:  if (w_load && (w_pend_sel == ENG_W'(i))) w_state_nxt[i] = S_IDLE;
                default: w_state_nxt[i] = S_IDLE;
            endcase
            if ((eng_done[i] && (r_state[i] != S_START) && (r_state[i] != S_RUN)) ||
                (eng_ready[i] && (r_state[i] != S_START)))
                w_spur = 1'b1;
            w_start_nxt[i] = (w_state_nxt[i] == S_START);
            if (w_state_nxt[i] != S_IDLE) w_cnt_nxt = w_cnt_nxt + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < N_ENG; i++) begin
                r_state[i] <= S_IDLE;
                r_tag[i]   <= '0;
            end
            r_eng_start  <= '0;
            r_rr_ptr     <= '0;
            r_cmp_ptr    <= '0;
            r_cmp_valid  <= 1'b0;
            r_cmp_tag    <= '0;
            r_cmp_eng    <= '0;
            r_active_cnt <= '0;
            r_err        <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < N_ENG; i++) r_state[i] <= w_state_nxt[i];
            r_eng_start  <= w_start_nxt;
            r_active_cnt <= w_cnt_nxt;
            if (w_spur) r_err <= 1'b1;
            if (w_accept) begin
                r_tag[w_acc_sel] <= job_tag;
                r_rr_ptr         <= ptr_inc(w_acc_sel);
            end
            if (w_load) begin
                r_cmp_valid <= 1'b1;
                r_cmp_tag   <= r_tag[w_pend_sel];
                r_cmp_eng   <= w_pend_sel;
                r_cmp_ptr   <= ptr_inc(w_pend_sel);
            end else if (cmp_ready) begin
                r_cmp_valid <= 1'b0;
            end
        end
    end

    assign job_ready    = |w_idle_vec;
    assign eng_start    = r_eng_start;
    assign cmp_valid    = r_cmp_valid;
    assign cmp_tag      = r_cmp_tag;
    assign cmp_eng      = r_cmp_eng;
    assign active_cnt   = r_active_cnt;
    assign err_spurious = r_err;

endmodule

// File: tb/tb_layernorm_engine_scheduler.sv
// Scenario bench for layernorm_engine_scheduler: the bench plays the engines, pushes expected
// completion records when it drives eng_done, and a monitor pops them on each accepted record.
module tb_layernorm_engine_scheduler;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       job_valid = 1'b0;
    logic [3:0] job_tag = '0;
    logic       job_ready;
    logic [3:0] eng_start;
    logic [3:0] eng_ready = '0;
    logic [3:0] eng_done = '0;
    logic       cmp_valid;
    logic [3:0] cmp_tag;
    logic [1:0] cmp_eng;
    logic       cmp_ready = 1'b1;
    logic [2:0] active_cnt;
    logic       err_spurious;

    typedef struct packed {
        logic [3:0] tag;
        logic [1:0] eng;
    } rec_t;

    rec_t sb[$];
    int   n_assert = 0;
    int   n_fail = 0;

    layernorm_engine_scheduler #(.N_ENG(4), .TAG_W(4), .ENG_W(2)) dut (
        .clock(clock), .reset(reset),
        .job_valid(job_valid), .job_tag(job_tag), .job_ready(job_ready),
        .eng_start(eng_start), .eng_ready(eng_ready), .eng_done(eng_done),
        .cmp_valid(cmp_valid), .cmp_tag(cmp_tag), .cmp_eng(cmp_eng), .cmp_ready(cmp_ready),
        .active_cnt(active_cnt), .err_spurious(err_spurious)
    );

    always #5 clock = ~clock;

    // Records are taken just before the edge that completes the handshake.
    always @(negedge clock) begin
        rec_t exp_r;
        #4;
        if (!reset && cmp_valid && cmp_ready) begin
            n_assert++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: got tag=%0d eng=%0d, expected no record", cmp_tag, cmp_eng);
            end else begin
                exp_r = sb.pop_front();
                if (cmp_tag !== exp_r.tag || cmp_eng !== exp_r.eng) begin
                    n_fail++;
                    $display("FAIL sb_record: got tag=%0d eng=%0d, expected tag=%0d eng=%0d",
                             cmp_tag, cmp_eng, exp_r.tag, exp_r.eng);
                end
            end
        end
    end

    task automatic push(input logic [3:0] tag, input logic [1:0] eng);
        rec_t r;
        r.tag = tag;
        r.eng = eng;
        sb.push_back(r);
    endtask

    task automatic do_reset();
        reset = 1'b1; job_valid = 1'b0; eng_ready = '0; eng_done = '0; cmp_ready = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        sb.delete();
    endtask

    task automatic ack(input logic [3:0] mask);
        eng_ready = mask;
        @(negedge clock);
        eng_ready = '0;
    endtask

    task automatic fin(input logic [3:0] mask);
        eng_done = mask;
        @(negedge clock);
        eng_done = '0;
    endtask

    task automatic send4(input int base);
        for (int t = 0; t < 4; t++) begin
            job_valid = 1'b1;
            job_tag   = 4'(base + t);
            @(negedge clock);
        end
        job_valid = 1'b0;
    endtask

    task automatic wait_drain();
        bit ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clock);
            if (active_cnt == 3'd0 && !cmp_valid) begin
                ok = 1'b1;
                break;
            end
        end
        n_assert++;
        if (!ok) begin n_fail++; $display("FAIL drain_timeout: got active=%0d cmp_valid=%0b, expected 0/0", active_cnt, cmp_valid); end
        n_assert++;
        if (sb.size() != 0) begin n_fail++; $display("FAIL drain_sb: got %0d records outstanding, expected 0", sb.size()); end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        n_assert++;
        if ({eng_start, cmp_valid, cmp_tag, cmp_eng, active_cnt, err_spurious, job_ready} !== {4'h0, 1'b0, 4'h0, 2'h0, 3'h0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_values: got start=%h cv=%b tag=%h eng=%h act=%0d err=%b jr=%b, expected 0,0,0,0,0,0,1",
                     eng_start, cmp_valid, cmp_tag, cmp_eng, active_cnt, err_spurious, job_ready);
        end
    endtask

    task automatic test_single_job();
        int cnt = 0;
        job_valid = 1'b1; job_tag = 4'd5;
        @(negedge clock);
        job_valid = 1'b0;
        n_assert++;
        if (active_cnt !== 3'd1) begin n_fail++; $display("FAIL single_active_up: got %0d, expected 1", active_cnt); end
        for (int k = 0; k < 12; k++) begin
            if (eng_start[0]) cnt++;
            eng_ready = (k == 3) ? 4'b0001 : 4'b0000;
            @(negedge clock);
        end
        eng_ready = '0;
        n_assert++;
        if (cnt != 4) begin n_fail++; $display("FAIL single_start_width: got %0d cycles, expected 4", cnt); end
        repeat (8) @(negedge clock);
        push(4'd5, 2'd0);
        fin(4'b0001);
        n_assert++;
        if (cmp_valid !== 1'b0 || active_cnt !== 3'd1) begin
            n_fail++; $display("FAIL single_pend: got cv=%b act=%0d, expected 0/1", cmp_valid, active_cnt);
        end
        @(negedge clock);
        n_assert++;
        if (cmp_valid !== 1'b1 || cmp_tag !== 4'd5 || cmp_eng !== 2'd0 || active_cnt !== 3'd0) begin
            n_fail++; $display("FAIL single_cmp: got cv=%b tag=%0d eng=%0d act=%0d, expected 1/5/0/0", cmp_valid, cmp_tag, cmp_eng, active_cnt);
        end
        wait_drain();
    endtask

    task automatic test_back_to_back();
        do_reset();
        send4(1);
        job_valid = 1'b1; job_tag = 4'd5;
        n_assert++;
        if (eng_start !== 4'hF || job_ready !== 1'b0 || active_cnt !== 3'd4) begin
            n_fail++; $display("FAIL b2b_full: got start=%h jr=%b act=%0d, expected f/0/4", eng_start, job_ready, active_cnt);
        end
        ack(4'hF);
        n_assert++;
        if (eng_start !== 4'h0) begin n_fail++; $display("FAIL b2b_start_drop: got %h, expected 0", eng_start); end
        repeat (3) begin
            @(negedge clock);
            n_assert++;
            if (job_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_blocked: got job_ready=%b, expected 0", job_ready); end
        end
        push(4'd3, 2'd2);
        fin(4'b0100);
        n_assert++;
        if (job_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_pend_busy: got job_ready=%b, expected 0", job_ready); end
        @(negedge clock);
        n_assert++;
        if (job_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_freed: got job_ready=%b, expected 1", job_ready); end
        @(negedge clock);
        job_valid = 1'b0;
        n_assert++;
        if (eng_start !== 4'b0100 || active_cnt !== 3'd4) begin
            n_fail++; $display("FAIL b2b_tag5: got start=%h act=%0d, expected 4/4", eng_start, active_cnt);
        end
        ack(4'b0100);
        push(4'd1, 2'd0); fin(4'b0001); repeat (3) @(negedge clock);
        push(4'd2, 2'd1); fin(4'b0010); repeat (3) @(negedge clock);
        push(4'd4, 2'd3); fin(4'b1000); repeat (3) @(negedge clock);
        push(4'd5, 2'd2); fin(4'b0100);
        wait_drain();
    endtask

    task automatic test_simultaneous_done();
        do_reset();
        send4(6);
        ack(4'hF);
        repeat (2) @(negedge clock);
        push(4'd7, 2'd1);
        push(4'd9, 2'd3);
        fin(4'b1010);
        n_assert++;
        if (cmp_valid !== 1'b0 || active_cnt !== 3'd4) begin
            n_fail++; $display("FAIL sim_pend: got cv=%b act=%0d, expected 0/4", cmp_valid, active_cnt);
        end
        @(negedge clock);
        n_assert++;
        if (cmp_valid !== 1'b1 || cmp_eng !== 2'd1) begin n_fail++; $display("FAIL sim_first: got cv=%b eng=%0d, expected 1/1", cmp_valid, cmp_eng); end
        @(negedge clock);
        n_assert++;
        if (cmp_valid !== 1'b1 || cmp_eng !== 2'd3) begin n_fail++; $display("FAIL sim_second: got cv=%b eng=%0d, expected 1/3", cmp_valid, cmp_eng); end
        @(negedge clock);
        push(4'd6, 2'd0);
        push(4'd8, 2'd2);
        fin(4'b0101);
        wait_drain();
    endtask

    task automatic test_backpressure();
        do_reset();
        send4(10);
        ack(4'hF);
        cmp_ready = 1'b0;
        push(4'd11, 2'd1);
        fin(4'b0010);
        @(negedge clock);
        job_valid = 1'b1; job_tag = 4'd14;
        @(negedge clock);
        job_valid = 1'b0;
        n_assert++;
        if (eng_start !== 4'b0010) begin n_fail++; $display("FAIL bp_refill: got start=%h, expected 2", eng_start); end
        ack(4'b0010);
        push(4'd12, 2'd2);
        push(4'd10, 2'd0);
        fin(4'b0101);
        for (int k = 0; k < 10; k++) begin
            n_assert++;
            if (cmp_valid !== 1'b1 || cmp_tag !== 4'd11 || cmp_eng !== 2'd1 || job_ready !== 1'b0 || active_cnt !== 3'd4) begin
                n_fail++;
                $display("FAIL bp_hold: got cv=%b tag=%0d eng=%0d jr=%b act=%0d, expected 1/11/1/0/4",
                         cmp_valid, cmp_tag, cmp_eng, job_ready, active_cnt);
            end
            @(negedge clock);
        end
        cmp_ready = 1'b1;
        repeat (5) @(negedge clock);
        push(4'd14, 2'd1); fin(4'b0010); repeat (2) @(negedge clock);
        push(4'd13, 2'd3); fin(4'b1000);
        wait_drain();
    endtask

    task automatic test_direct_pend_spurious();
        do_reset();
        job_valid = 1'b1; job_tag = 4'd7;
        @(negedge clock);
        job_valid = 1'b0;
        eng_ready = 4'b0001;
        push(4'd7, 2'd0);
        fin(4'b0001);
        eng_ready = '0;
        n_assert++;
        if (eng_start !== 4'h0 || active_cnt !== 3'd1 || cmp_valid !== 1'b0) begin
            n_fail++; $display("FAIL direct_pend: got start=%h act=%0d cv=%b, expected 0/1/0", eng_start, active_cnt, cmp_valid);
        end
        @(negedge clock);
        n_assert++;
        if (cmp_valid !== 1'b1 || err_spurious !== 1'b0) begin
            n_fail++; $display("FAIL direct_cmp: got cv=%b err=%b, expected 1/0", cmp_valid, err_spurious);
        end
        @(negedge clock);
        fin(4'b0100);
        n_assert++;
        if (err_spurious !== 1'b1) begin n_fail++; $display("FAIL spur_set: got %b, expected 1", err_spurious); end
        repeat (5) @(negedge clock);
        n_assert++;
        if (err_spurious !== 1'b1 || active_cnt !== 3'd0 || cmp_valid !== 1'b0) begin
            n_fail++; $display("FAIL spur_sticky: got err=%b act=%0d cv=%b, expected 1/0/0", err_spurious, active_cnt, cmp_valid);
        end
        wait_drain();
    endtask

    task automatic test_reset_midflight();
        bit seen = 1'b0;
        do_reset();
        for (int t = 1; t <= 3; t++) begin
            job_valid = 1'b1; job_tag = 4'(t);
            @(negedge clock);
        end
        job_valid = 1'b0;
        ack(4'b0111);
        cmp_ready = 1'b0;
        fin(4'b0010);
        @(negedge clock);
        n_assert++;
        if (cmp_valid !== 1'b1) begin n_fail++; $display("FAIL mid_cv_before: got %b, expected 1", cmp_valid); end
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        n_assert++;
        if ({eng_start, cmp_valid, cmp_tag, cmp_eng, active_cnt, err_spurious, job_ready} !== {4'h0, 1'b0, 4'h0, 2'h0, 3'h0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL mid_reset_values: got start=%h cv=%b tag=%h eng=%h act=%0d err=%b jr=%b, expected 0,0,0,0,0,0,1",
                     eng_start, cmp_valid, cmp_tag, cmp_eng, active_cnt, err_spurious, job_ready);
        end
        cmp_ready = 1'b1;
        repeat (5) begin
            @(negedge clock);
            if (cmp_valid) seen = 1'b1;
        end
        n_assert++;
        if (seen) begin n_fail++; $display("FAIL mid_no_cmp: got a completion after reset, expected none"); end
        job_valid = 1'b1; job_tag = 4'd9;
        @(negedge clock);
        job_valid = 1'b0;
        n_assert++;
        if (eng_start !== 4'b0001) begin n_fail++; $display("FAIL mid_fresh_eng: got start=%h, expected 1", eng_start); end
        ack(4'b0001);
        push(4'd9, 2'd0);
        fin(4'b0001);
        wait_drain();
    endtask

    initial begin
        @(negedge clock);
        test_reset();
        test_single_job();
        test_back_to_back();
        test_simultaneous_done();
        test_backpressure();
        test_direct_pend_spurious();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/layernorm_engine_scheduler.md
# layernorm_engine_scheduler

Dispatches row-normalisation jobs across a pool of identical `layernorm_1d` engine instances instantiated under `myproject`, using each engine's `ap_start`/`ap_ready`/`ap_done` block-level handshake. Accepts tagged jobs on a valid/ready port and selects a free engine round-robin. Returns one completion record (tag and engine index) per job on a second valid/ready port. Sits between the top-level row sequencer and the engine pool, replacing the fixed per-engine call order.

## Interface
- `N_ENG`, 4: number of engines in the pool (2..8)
- `TAG_W`, 4: job tag width
- `ENG_W`, 2: engine index width, equal to clog2(`N_ENG`)
- `clock`  in  1  single clock; all logic is rising-edge
- `reset`  in  1  synchronous, active-high; clears all state
- `job_valid`  in  1  job request valid
- `job_tag`  in  `TAG_W`  tag carried back on completion
- `job_ready`  out  1  scheduler can accept a job this cycle
- `eng_start`  out  `N_ENG`  per-engine `ap_start`
- `eng_ready`  in  `N_ENG`  per-engine `ap_ready` (1-cycle pulse)
- `eng_done`  in  `N_ENG`  per-engine `ap_done` (1-cycle pulse)
- `cmp_valid`  out  1  completion record valid
- `cmp_tag`  out  `TAG_W`  tag of the completed job
- `cmp_eng`  out  `ENG_W`  engine that ran the job
- `cmp_ready`  in  1  consumer accepts the completion
- `active_cnt`  out  clog2(`N_ENG`+1)  number of engines not in IDLE
- `err_spurious`  out  1  sticky; set on `eng_done` or `eng_ready` received in an unexpected state

## Operation
- Each engine has a 4-state FSM:
  - IDLE -> START on job accept assigned to it.
  - START -> RUN on `eng_ready`.
  - START -> PEND on `eng_ready` and `eng_done` in the same cycle.
  - RUN -> PEND on `eng_done`.
  - PEND -> IDLE when its record is loaded into the completion register.
- `eng_start[i]` = (state[i] == START), driven from a register. It stays high until `eng_ready[i]` is sampled, then is low in the next cycle.
- `job_ready` = any engine IDLE. It is a function of registered state only; there is no combinational path from `job_valid`.
- On accept, the scheduler picks the first IDLE engine at or after `rr_ptr`, with wrap-around. It stores `job_tag` in `tag[i]`, sets state[i]=START and sets `rr_ptr` = i+1 mod `N_ENG`.
- Completion register (`cmp_valid`/`cmp_tag`/`cmp_eng`):
  - Loaded when (!`cmp_valid` or `cmp_ready`) and at least one engine is in PEND.
  - Source is the first PEND engine at or after `cmp_ptr`; then `cmp_ptr` = i+1 mod `N_ENG`.
  - Cleared on `cmp_ready` when no engine is in PEND.
  - Outputs hold stable while `cmp_valid` && !`cmp_ready`.
- `eng_done[i]` outside START/RUN, or `eng_ready[i]` outside START, sets `err_spurious` and is otherwise ignored.
- Completions may return out of order with respect to accepts; tags identify the jobs.

## Timing
- Reset values: `eng_start`=0, `cmp_valid`=0, `cmp_tag`=0, `cmp_eng`=0, `active_cnt`=0, `err_spurious`=0, `job_ready`=1 in the cycle after reset. All FSMs return to IDLE, `rr_ptr`=`cmp_ptr`=0.
- Reset mid-operation drops all in-flight jobs with no completions emitted. Engines must share the same reset.
- Accept at edge t: `eng_start[i]`=1 in cycle t+1.
- `eng_done[i]` sampled at edge d: PEND at d+1. `cmp_valid`=1 from d+2 if the completion register is free or drained at d+1.
- Minimum accept-to-`cmp_valid` latency is engine latency + 2 cycles.
- A job can be accepted in the same cycle an engine leaves PEND. That engine is not reusable until the following cycle, since `job_ready` uses pre-edge state.
- When all engines are busy, `job_ready`=0 and jobs wait. Throughput is bounded by `N_ENG` concurrent jobs.
- With simultaneous `eng_done` on several engines, all enter PEND. They drain one per cycle in round-robin order with `cmp_ready` held high.
- `active_cnt` counts engines in START, RUN or PEND, registered and updated the same edge as the FSMs.

## Test plan
- Reset, then one job with tag=5; engine 0 asserts ready after 3 cycles and done after 20 -> `eng_start[0]` high for exactly 4 cycles; `cmp_valid` with tag=5, eng=0 two cycles after done; `active_cnt` 1->0.
- Five back-to-back jobs, tags 1..5, with `N_ENG`=4 and all engines slow -> tags 1..4 go to engines 0..3; `job_ready`=0 until the first engine drains; tag 5 goes to the freed engine.
- Engines 1 and 3 assert done in the same cycle with `cmp_ready`=1 -> two completions on consecutive cycles in `cmp_ptr` order; no record lost.
- `cmp_ready`=0 for 10 cycles while two engines finish -> outputs hold stable, both engines stay in PEND, `job_ready`=0 if no engine is IDLE; both records drain after release.
- `eng_ready` and `eng_done` together in START -> direct START->PEND transition and a correct completion; a stray `eng_done[2]` while engine 2 is IDLE -> `err_spurious`=1 and stays 1.
- Reset asserted with 3 jobs in flight and `cmp_valid`=1 -> next cycle all outputs are at reset values, no completion is emitted, and a fresh job goes to engine 0.
